// File: rtl/gf7_mult_serial.sv
`default_nettype none
// ============================================================================
// Module   : gf7_mult_serial
// Brief    : MSB-first serial GF(2^7) multiplier, P(x)=x^7+x+1. Define
//            GF7_MULT_RADIX4_EN to process two multiplier bits per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module gf7_mult_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] a,
    input  logic [6:0] b,
    output logic       busy,
    output logic       done,
    output logic [6:0] p,
    output logic       is_one
);

    localparam int         W    = 7;
    localparam logic [7:0] POLY = 8'h83;
    localparam logic [6:0] RED  = POLY[6:0];

`ifdef GF7_MULT_RADIX4_EN
    localparam logic [2:0] CNT_INIT = 3'd3;
`else
    localparam logic [2:0] CNT_INIT = 3'd6;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_acc;
    logic [2:0]     r_cnt;
    logic [W-1:0]   w_acc_nxt;

    // Multiply by x with reduction applied on x^7 overflow.
    function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? RED : '0);
    endfunction

`ifdef GF7_MULT_RADIX4_EN
    logic [W:0]   w_b8;
    logic [2:0]   w_idx_hi;
    logic [2:0]   w_idx_lo;
    assign w_b8      = {1'b0, r_b};
    assign w_idx_hi  = {r_cnt[1:0], 1'b1};
    assign w_idx_lo  = {r_cnt[1:0], 1'b0};
    assign w_acc_nxt = xtime(xtime(r_acc) ^ (w_b8[w_idx_hi] ? r_a : '0))
                       ^ (w_b8[w_idx_lo] ? r_a : '0);
`else
    assign w_acc_nxt = xtime(r_acc) ^ (r_b[r_cnt] ? r_a : '0);
`endif

    assign w_last = (r_cnt == 3'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_accept    = load;
                w_state_nxt = load ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            p       <= '0;
            is_one  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= '0;
                r_cnt <= CNT_INIT;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 3'd1;
                if (w_last) begin
                    p      <= w_acc_nxt;
                    is_one <= (w_acc_nxt == 7'h01);
                end
            end
        end
    end

    // Status flags are decoded straight from the state register.
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire
